// File: rtl/instruction_fetch_if.sv
// Fetch unit bus: control strobes, program-memory port and fetch state.
interface instruction_fetch_if;
    logic        instr_rd_en;
    logic        instr_flush;
    logic        pc_incr_en;
    logic        pc_j_en;
    logic        stack_push;
    logic        stack_pop;
    logic [1:0]  pclath_hi;
    logic [13:0] pm_data;
    logic [12:0] pm_addr;
    logic [12:0] pc;
    logic [13:0] instr_current;
    logic [2:0]  stack_ptr;

    modport master (
        output instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
        output stack_push, stack_pop, pclath_hi, pm_data,
        input  pm_addr, pc, instr_current, stack_ptr
    );

    modport slave (
        input  instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
        input  stack_push, stack_pop, pclath_hi, pm_data,
        output pm_addr, pc, instr_current, stack_ptr
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: 13-bit PC, instruction register, 8-deep circular return stack.
module instruction_fetch (
    input  logic clk,
    input  logic rst,
    instruction_fetch_if.slave bus
);
    logic [12:0] pc_q;
    logic [12:0] pc_d;
    logic [13:0] ir_q;
    logic [13:0] ir_d;
    logic [2:0]  ptr_q;
    logic [2:0]  ptr_d;
    logic [2:0]  ptr_dec;
    logic [12:0] stack_q [8];
    logic [12:0] jump_target;
    logic        stack_wr;

    assign ptr_dec     = ptr_q - 3'd1;
    assign jump_target = {bus.pclath_hi, ir_q[10:0]};
    // a simultaneous pop wins, so the push never writes
    assign stack_wr    = bus.stack_push && !bus.stack_pop;

    always_comb begin
        pc_d = pc_q;
        if (bus.stack_pop)
            pc_d = stack_q[ptr_dec];
        else if (bus.pc_j_en)
            pc_d = jump_target;
        else if (bus.pc_incr_en)
            pc_d = pc_q + 13'd1;
    end

    always_comb begin
        ir_d = ir_q;
        if (bus.instr_flush)
            ir_d = 14'h0000;
        else if (bus.instr_rd_en)
            ir_d = bus.pm_data;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (bus.stack_pop)
            ptr_d = ptr_dec;
        else if (bus.stack_push)
            ptr_d = ptr_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q  <= '0;
            ir_q  <= '0;
            ptr_q <= '0;
            for (int i = 0; i < 8; i++)
                stack_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            ptr_q <= ptr_d;
            if (stack_wr)
                stack_q[ptr_q] <= pc_q;
        end
    end

    assign bus.pm_addr       = pc_q;
    assign bus.pc            = pc_q;
    assign bus.instr_current = ir_q;
    assign bus.stack_ptr     = ptr_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a per-cycle reference model.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [13:0] mem [8192];
    assign bus.pm_data = mem[bus.pm_addr];

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    int m_pc;
    int m_ir;
    int m_ptr;
    int m_stk [8];

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%h req=%h t=%0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("model_pc", int'(bus.pc), m_pc);
            chk("model_pm_addr", int'(bus.pm_addr), m_pc);
            chk("model_instr", int'(bus.instr_current), m_ir);
            chk("model_ptr", int'(bus.stack_ptr), m_ptr);
        end
    end

    // Reference: evaluate the next state from the current model state and strobes.
    task automatic model_step(input bit r, rd, fl, inc, j, pu, po, input int hi);
        int npc;
        int nir;
        if (!r) begin
            m_pc = 0;
            m_ir = 0;
            m_ptr = 0;
            for (int i = 0; i < 8; i++) m_stk[i] = 0;
            return;
        end
        npc = m_pc;
        if (po) npc = m_stk[(m_ptr + 7) % 8];
        else if (j) npc = hi * 2048 + (m_ir % 2048);
        else if (inc) npc = (m_pc + 1) % 8192;
        nir = m_ir;
        if (fl) nir = 0;
        else if (rd) nir = int'(mem[m_pc]);
        if (po) begin
            m_ptr = (m_ptr + 7) % 8;
        end else if (pu) begin
            m_stk[m_ptr] = m_pc;
            m_ptr = (m_ptr + 1) % 8;
        end
        m_pc = npc;
        m_ir = nir;
    endtask

    task automatic cyc(input bit r, rd, fl, inc, j, pu, po, input int hi);
        @(negedge clk);
        rst = r;
        bus.instr_rd_en = rd;
        bus.instr_flush = fl;
        bus.pc_incr_en = inc;
        bus.pc_j_en = j;
        bus.stack_push = pu;
        bus.stack_pop = po;
        bus.pclath_hi = 2'(hi);
        @(posedge clk);
        model_step(r, rd, fl, inc, j, pu, po, hi);
        #1;
    endtask

    int wrap_seq [8] = '{8, 7, 6, 5, 4, 3, 2, 9};

    initial begin
        bus.instr_rd_en = 0;
        bus.instr_flush = 0;
        bus.pc_incr_en = 0;
        bus.pc_j_en = 0;
        bus.stack_push = 0;
        bus.stack_pop = 0;
        bus.pclath_hi = 0;
        for (int i = 0; i < 8192; i++) mem[i] = 14'(i * 37 + 5);
        mem[0] = 14'h1A01;
        mem[1] = 14'h2B02;
        mem[2] = 14'h3C03;
        mem[3] = 14'h2855;
        mem[7] = 14'h07FF;
        mem[13'h010] = 14'h2100;
        mem[13'h855] = 14'h0010;

        //   rst rd fl inc j pu po hi
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        run = 1'b1;
        chk("rst_pc", int'(bus.pc), 0);
        chk("rst_instr", int'(bus.instr_current), 0);
        chk("rst_ptr", int'(bus.stack_ptr), 0);

        cyc(1, 1, 0, 1, 0, 0, 0, 0);
        chk("seq1_instr", int'(bus.instr_current), 'h1A01);
        chk("seq1_pc", int'(bus.pc), 1);
        cyc(1, 1, 0, 1, 0, 0, 0, 0);
        chk("seq2_instr", int'(bus.instr_current), 'h2B02);
        chk("seq2_pc", int'(bus.pc), 2);
        cyc(1, 1, 0, 1, 0, 0, 0, 0);
        chk("seq3_instr", int'(bus.instr_current), 'h3C03);
        chk("seq3_pc", int'(bus.pc), 3);

        cyc(1, 1, 0, 1, 0, 0, 0, 0);
        chk("goto_ir", int'(bus.instr_current), 'h2855);
        cyc(1, 0, 1, 0, 1, 0, 0, 1);
        chk("goto_pc", int'(bus.pc), 'h0855);
        chk("goto_flush", int'(bus.instr_current), 0);
        cyc(1, 1, 0, 1, 0, 0, 0, 0);
        chk("goto_fetch_instr", int'(bus.instr_current), 'h0010);
        chk("goto_fetch_pc", int'(bus.pc), 'h0856);

        cyc(1, 0, 1, 0, 1, 0, 0, 0);
        chk("to_010", int'(bus.pc), 'h010);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        chk("rd_only_pc", int'(bus.pc), 'h010);
        cyc(1, 0, 1, 0, 1, 1, 0, 0);
        chk("call_pc", int'(bus.pc), 'h100);
        chk("call_ptr", int'(bus.stack_ptr), 1);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        chk("sub_pc", int'(bus.pc), 'h102);
        cyc(1, 0, 1, 0, 0, 0, 1, 0);
        chk("ret_pc", int'(bus.pc), 'h010);
        chk("ret_ptr", int'(bus.stack_ptr), 0);
        chk("ret_instr", int'(bus.instr_current), 0);

        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 1, 0, 1, 0, 0);
        chk("wrap_ptr", int'(bus.stack_ptr), 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        chk("wrap_pop_pc", int'(bus.pc), 9);
        chk("wrap_pop_ptr", int'(bus.stack_ptr), 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("wrap_seq%0d", i), int'(bus.pc), wrap_seq[i]);
        end

        cyc(1, 0, 0, 1, 1, 0, 1, 2);
        chk("pop_j_inc_pc", int'(bus.pc), 8);
        chk("pop_j_inc_ptr", int'(bus.stack_ptr), 7);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0);
        chk("flush_rd", int'(bus.instr_current), 0);
        cyc(1, 0, 0, 0, 0, 1, 1, 0);
        chk("push_pop_ptr", int'(bus.stack_ptr), 6);
        chk("push_pop_pc", int'(bus.pc), 7);

        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 3);
        chk("to_1fff", int'(bus.pc), 'h1FFF);
        cyc(0, 0, 0, 0, 1, 1, 0, 3);
        chk("rst_mid_pc", int'(bus.pc), 0);
        chk("rst_mid_ptr", int'(bus.stack_ptr), 0);
        chk("rst_mid_instr", int'(bus.instr_current), 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        chk("rst_stack_clear", int'(bus.pc), 0);
        chk("rst_pop_ptr", int'(bus.stack_ptr), 7);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 3);
        chk("to_1fff_b", int'(bus.pc), 'h1FFF);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        chk("incr_wrap", int'(bus.pc), 0);
        cyc(1, 1, 0, 1, 0, 0, 0, 0);
        chk("after_wrap_instr", int'(bus.instr_current), 'h1A01);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
